board_move_ctrl: RTL and testbench

BOARD_MOVE_CTRL -- requirements
Module: board_move_ctrl

---
 rtl/board_pkg.sv | 44 ++++
 rtl/board_move_ctrl_btn_edge.sv | 20 ++
 rtl/board_move_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_board_move_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - piece encoding, colours, FSM states and chess start position
package board_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  // Square code is {type, colour, occupied}; rows 0-1 black, rows 6-7 white.
  function automatic logic [4:0] start_piece(input int row, input int col);
    piece_t t;
    logic   c;
    t = NONE;
    c = (row < 2) ? BLACK : WHITE;
    if (row == 1 || row == 6) begin
      t = PAWN;
    end else if (row == 0 || row == 7) begin
      case (col)
        0, 7:    t = ROOK;
        1, 6:    t = KNIGHT;
        2, 5:    t = BISHOP;
        3:       t = QUEEN;
        default: t = KING;
      endcase
    end
    return (t == NONE) ? 5'd0 : {t, c, 1'b1};
  endfunction

endpackage

// File: rtl/board_move_ctrl_btn_edge.sv
// rtl/board_move_ctrl_btn_edge.sv - rising-edge detect for a vector of synchronised buttons
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/board_move_ctrl.sv
// rtl/board_move_ctrl.sv - chess board cursor/select/place controller with external legality checker
// Optional macro BOARD_UNDO_EN adds a btn_undo input and a one-level undo record.
module board_move_ctrl
  import board_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int PIECE_W     = 5,
  parameter int CHK_TIMEOUT = 16,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rowChange,
  input  logic               columnChange,
  input  logic               UP,
  input  logic               select,
  input  logic               place,
  input  logic               chk_ack,
  input  logic               chk_legal,
  input  logic [RW-1:0]      rd_row,
  input  logic [CW-1:0]      rd_col,
  output logic [PIECE_W-1:0] rd_piece,
  output logic [RW-1:0]      cur_row,
  output logic [CW-1:0]      cur_col,
  output logic               sel_valid,
  output logic [RW-1:0]      sel_row,
  output logic [CW-1:0]      sel_col,
  output logic               turn,
  output logic               chk_req,
  output logic [RW-1:0]      chk_src_row,
  output logic [CW-1:0]      chk_src_col,
  output logic [RW-1:0]      chk_dst_row,
  output logic [CW-1:0]      chk_dst_col,
  output logic [PIECE_W-1:0] chk_piece,
  output logic               move_done,
  output logic               move_err
`ifdef BOARD_UNDO_EN
  ,
  input  logic               btn_undo
`endif
);

  localparam int TW = $clog2(CHK_TIMEOUT + 1);
  localparam bit START_EN = (ROWS == 8) && (COLS == 8) && (PIECE_W >= 5);
  localparam logic [RW:0] ROWS_L = (RW + 1)'(ROWS);
  localparam logic [CW:0] COLS_L = (CW + 1)'(COLS);

`ifdef BOARD_UNDO_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  state_t             state;
  logic [PIECE_W-1:0] board [ROWS][COLS];
  logic [PIECE_W-1:0] sel_piece;
  logic [TW-1:0]      tmr;

  logic [NB-1:0] btn_level, btn_rise;
  logic          row_rise, col_rise, sel_rise, place_rise;

`ifdef BOARD_UNDO_EN
  assign btn_level = {btn_undo, place, select, columnChange, rowChange};
`else
  assign btn_level = {place, select, columnChange, rowChange};
`endif

  btn_edge #(.W(NB)) u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_level),
    .rise  (btn_rise)
  );

  assign row_rise   = btn_rise[0];
  assign col_rise   = btn_rise[1];
  assign sel_rise   = btn_rise[2];
  assign place_rise = btn_rise[3];

  logic [RW-1:0]      row_inc, row_dec;
  logic [CW-1:0]      col_inc, col_dec;
  logic [PIECE_W-1:0] cur_piece;
  logic               own_piece, on_held;

  assign row_inc = (cur_row == RW'(ROWS - 1)) ? '0 : cur_row + 1'b1;
  assign row_dec = (cur_row == '0) ? RW'(ROWS - 1) : cur_row - 1'b1;
  assign col_inc = (cur_col == CW'(COLS - 1)) ? '0 : cur_col + 1'b1;
  assign col_dec = (cur_col == '0) ? CW'(COLS - 1) : cur_col - 1'b1;

  // Decisions always use the pre-step cursor, so a same-cycle step cannot retarget an action.
  assign cur_piece = board[cur_row][cur_col];
  assign own_piece = cur_piece[0] && (cur_piece[1] == turn);
  assign on_held   = (cur_row == sel_row) && (cur_col == sel_col);

  assign chk_src_row = sel_row;
  assign chk_src_col = sel_col;
  assign chk_piece   = sel_piece;

`ifdef BOARD_UNDO_EN
  logic               undo_rise, undo_fire, rec_valid;
  logic [RW-1:0]      rec_src_row, rec_dst_row;
  logic [CW-1:0]      rec_src_col, rec_dst_col;
  logic [PIECE_W-1:0] rec_moved, rec_cap, dst_piece;

  assign undo_rise = btn_rise[NB-1];
  assign undo_fire = (state == S_IDLE) && undo_rise && !place_rise && !sel_rise && rec_valid;
  assign dst_piece = board[chk_dst_row][chk_dst_col];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cur_row     <= '0;
      cur_col     <= '0;
      sel_valid   <= 1'b0;
      sel_row     <= '0;
      sel_col     <= '0;
      sel_piece   <= '0;
      turn        <= WHITE;
      chk_req     <= 1'b0;
      chk_dst_row <= '0;
      chk_dst_col <= '0;
      move_done   <= 1'b0;
      move_err    <= 1'b0;
      tmr         <= '0;
`ifdef BOARD_UNDO_EN
      rec_valid   <= 1'b0;
      rec_src_row <= '0;
      rec_src_col <= '0;
      rec_dst_row <= '0;
      rec_dst_col <= '0;
      rec_moved   <= '0;
      rec_cap     <= '0;
`endif
    end else begin
      move_done <= 1'b0;
      move_err  <= 1'b0;
      if (row_rise) cur_row <= UP ? row_inc : row_dec;
      if (col_rise) cur_col <= UP ? col_inc : col_dec;

      case (state)
        S_IDLE: begin
          if (place_rise) begin
            move_err <= 1'b1;
          end else if (sel_rise) begin
            if (own_piece) begin
              sel_row   <= cur_row;
              sel_col   <= cur_col;
              sel_piece <= cur_piece;
              sel_valid <= 1'b1;
              state     <= S_HOLD;
            end else begin
              move_err <= 1'b1;
            end
          end
`ifdef BOARD_UNDO_EN
          else if (undo_rise) begin
            if (rec_valid) begin
              turn      <= ~turn;
              rec_valid <= 1'b0;
              move_done <= 1'b1;
            end else begin
              move_err <= 1'b1;
            end
          end
`endif
        end

        S_HOLD: begin
          if (place_rise) begin
            if (on_held || own_piece) begin
              move_err <= 1'b1;
            end else begin
              chk_dst_row <= cur_row;
              chk_dst_col <= cur_col;
              chk_req     <= 1'b1;
              tmr         <= '0;
              state       <= S_CHECK;
            end
          end else if (sel_rise) begin
            if (on_held) begin
              sel_valid <= 1'b0;
              state     <= S_IDLE;
            end else if (own_piece) begin
              sel_row   <= cur_row;
              sel_col   <= cur_col;
              sel_piece <= cur_piece;
            end else begin
              move_err <= 1'b1;
            end
          end
`ifdef BOARD_UNDO_EN
          else if (undo_rise) begin
            move_err <= 1'b1;
          end
`endif
        end

        S_CHECK: begin
          if (chk_ack) begin
            chk_req <= 1'b0;
            tmr     <= '0;
            if (chk_legal) begin
              state <= S_COMMIT;
            end else begin
              move_err <= 1'b1;
              state    <= S_HOLD;
            end
          end else if (tmr == TW'(CHK_TIMEOUT - 1)) begin
            chk_req  <= 1'b0;
            tmr      <= '0;
            move_err <= 1'b1;
            state    <= S_HOLD;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_COMMIT: begin
          turn      <= ~turn;
          move_done <= 1'b1;
          sel_valid <= 1'b0;
          state     <= S_IDLE;
`ifdef BOARD_UNDO_EN
          rec_valid   <= 1'b1;
          rec_src_row <= sel_row;
          rec_src_col <= sel_col;
          rec_dst_row <= chk_dst_row;
          rec_dst_col <= chk_dst_col;
          rec_moved   <= sel_piece;
          rec_cap     <= dst_piece;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-square write port: port a lands the moving piece, port b rewrites the origin.
  logic               wr_en;
  logic [RW-1:0]      wa_row, wb_row;
  logic [CW-1:0]      wa_col, wb_col;
  logic [PIECE_W-1:0] wa_data, wb_data;

  always_comb begin
    wr_en   = 1'b0;
    wa_row  = chk_dst_row;
    wa_col  = chk_dst_col;
    wa_data = sel_piece;
    wb_row  = sel_row;
    wb_col  = sel_col;
    wb_data = '0;
    if (state == S_COMMIT) begin
      wr_en = 1'b1;
    end
`ifdef BOARD_UNDO_EN
    else if (undo_fire) begin
      wr_en   = 1'b1;
      wa_row  = rec_dst_row;
      wa_col  = rec_dst_col;
      wa_data = rec_cap;
      wb_row  = rec_src_row;
      wb_col  = rec_src_col;
      wb_data = rec_moved;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board[r][c] <= START_EN ? PIECE_W'(start_piece(r, c)) : '0;
    end else if (wr_en) begin
      board[wa_row][wa_col] <= wa_data;
      board[wb_row][wb_col] <= wb_data;
    end
  end

  logic rd_in_range;
  assign rd_in_range = ({1'b0, rd_row} < ROWS_L) && ({1'b0, rd_col} < COLS_L);

  // Forward same-cycle writes so the read port shows a commit the very next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                              rd_piece <= '0;
    else if (!rd_in_range)                                  rd_piece <= '0;
    else if (wr_en && rd_row == wa_row && rd_col == wa_col) rd_piece <= wa_data;
    else if (wr_en && rd_row == wb_row && rd_col == wb_col) rd_piece <= wb_data;
    else                                                    rd_piece <= board[rd_row][rd_col];
  end

endmodule

// File: tb/tb_board_move_ctrl.sv
// tb/tb_board_move_ctrl.sv - scoreboard bench for board_move_ctrl
module tb_board_move_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rowChange = 1'b0, columnChange = 1'b0, UP = 1'b0;
  logic       select = 1'b0, place = 1'b0;
  logic       chk_ack = 1'b0, chk_legal = 1'b0;
  logic [2:0] rd_row = '0, rd_col = '0;
  logic [4:0] rd_piece, chk_piece;
  logic [2:0] cur_row, cur_col, sel_row, sel_col;
  logic [2:0] chk_src_row, chk_src_col, chk_dst_row, chk_dst_col;
  logic       sel_valid, turn, chk_req, move_done, move_err;
`ifdef BOARD_UNDO_EN
  logic       btn_undo = 1'b0;
`endif

  always #5 clk = ~clk;

  board_move_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rowChange    (rowChange),
    .columnChange (columnChange),
    .UP           (UP),
    .select       (select),
    .place        (place),
    .chk_ack      (chk_ack),
    .chk_legal    (chk_legal),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rd_piece     (rd_piece),
    .cur_row      (cur_row),
    .cur_col      (cur_col),
    .sel_valid    (sel_valid),
    .sel_row      (sel_row),
    .sel_col      (sel_col),
    .turn         (turn),
    .chk_req      (chk_req),
    .chk_src_row  (chk_src_row),
    .chk_src_col  (chk_src_col),
    .chk_dst_row  (chk_dst_row),
    .chk_dst_col  (chk_dst_col),
    .chk_piece    (chk_piece),
    .move_done    (move_done),
    .move_err     (move_err)
`ifdef BOARD_UNDO_EN
    ,
    .btn_undo     (btn_undo)
`endif
  );

  int checks = 0;
  int fails  = 0;

  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  logic [1:0] evq[$];
  logic [4:0] rdq[$];
  logic       rd_go = 1'b0, rd_v = 1'b0;
  logic       watch_en = 1'b0;
  logic [4:0] watch_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_v <= rd_go;

  always @(negedge clk) begin
    if (!reset) begin
      if (move_done || move_err) begin
        if (evq.size() == 0) chk("unexpected_event", 32'({move_done, move_err}), 32'd0);
        else                 chk("event", 32'({move_done, move_err}), 32'(evq.pop_front()));
        if (move_done && watch_en) chk("rd_after_commit", 32'(rd_piece), 32'(watch_val));
      end
      if (rd_v && rdq.size() > 0) chk("rd_piece", 32'(rd_piece), 32'(rdq.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit is_row, input bit up, input int n);
    for (int i = 0; i < n; i++) begin
      UP = up;
      if (is_row) rowChange = 1'b1;
      else        columnChange = 1'b1;
      tick();
      rowChange = 1'b0;
      columnChange = 1'b0;
      tick();
    end
  endtask

  task automatic press_sel();
    select = 1'b1; tick(); select = 1'b0; tick();
  endtask

  task automatic press_place();
    place = 1'b1; tick(); place = 1'b0; tick();
  endtask

  task automatic read_sq(input int r, input int c, input logic [4:0] exp);
    rd_row = 3'(r);
    rd_col = 3'(c);
    rdq.push_back(exp);
    rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // Reset state, sampled while reset is held.
    @(negedge clk);
    chk("rst_cur_row", 32'(cur_row), 32'd0);
    chk("rst_cur_col", 32'(cur_col), 32'd0);
    chk("rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_chk_req", 32'(chk_req), 32'd0);
    chk("rst_move_done", 32'(move_done), 32'd0);
    chk("rst_move_err", 32'(move_err), 32'd0);
    chk("rst_rd_piece", 32'(rd_piece), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Start position.
    read_sq(7, 4, 5'b11001);
    read_sq(0, 0, 5'b10011);
    read_sq(0, 4, 5'b11011);
    read_sq(6, 3, 5'b00101);
    read_sq(3, 3, 5'b00000);

    // Cursor wrap.
    step(1, 0, 1);
    chk("wrap_row_down", 32'(cur_row), 32'd7);
    step(0, 0, 1);
    chk("wrap_col_down", 32'(cur_col), 32'd7);
    step(0, 1, 1);
    chk("wrap_col_up", 32'(cur_col), 32'd0);

    // Wrong-colour select and place in IDLE.
    step(1, 1, 2);
    chk("cursor_1_0", 32'(cur_row), 32'd1);
    evq.push_back(EV_ERR);
    press_sel();
    chk("black_sel_no_hold", 32'(sel_valid), 32'd0);
    evq.push_back(EV_ERR);
    press_place();

    // Legal move e2-e4 with a 3-cycle checker response.
    do_reset();
    step(1, 1, 6);
    step(0, 1, 4);
    press_sel();
    chk("hold_valid", 32'(sel_valid), 32'd1);
    chk("hold_sq", 32'({sel_row, sel_col}), 32'({3'd6, 3'd4}));
    step(1, 0, 2);
    rd_row = 3'd4;
    rd_col = 3'd4;
    watch_val = 5'b00101;
    watch_en = 1'b1;
    evq.push_back(EV_DONE);
    press_place();
    chk("chk_req_high", 32'(chk_req), 32'd1);
    chk("chk_src", 32'({chk_src_row, chk_src_col}), 32'({3'd6, 3'd4}));
    chk("chk_dst", 32'({chk_dst_row, chk_dst_col}), 32'({3'd4, 3'd4}));
    chk("chk_piece", 32'(chk_piece), 32'(5'b00101));
    tick(); tick();
    chk("chk_req_stable", 32'(chk_req), 32'd1);
    chk_ack = 1'b1;
    chk_legal = 1'b1;
    tick();
    chk_ack = 1'b0;
    chk_legal = 1'b0;
    tick(); tick(); tick();
    watch_en = 1'b0;
    chk("turn_black", 32'(turn), 32'd1);
    chk("commit_clear_sel", 32'(sel_valid), 32'd0);
    chk("commit_chk_req_low", 32'(chk_req), 32'd0);
    read_sq(4, 4, 5'b00101);
    read_sq(6, 4, 5'b00000);

`ifdef BOARD_UNDO_EN
    evq.push_back(EV_DONE);
    btn_undo = 1'b1; tick(); btn_undo = 1'b0; tick(); tick();
    chk("undo_turn", 32'(turn), 32'd0);
    read_sq(6, 4, 5'b00101);
    read_sq(4, 4, 5'b00000);
    evq.push_back(EV_ERR);
    btn_undo = 1'b1; tick(); btn_undo = 1'b0; tick(); tick();
    chk("undo2_turn", 32'(turn), 32'd0);
`endif

    // Checker timeout: select a2, place a3, never acknowledge.
    do_reset();
    step(1, 0, 2);
    press_sel();
    chk("hold_a2", 32'(sel_valid), 32'd1);
    step(1, 0, 1);
    evq.push_back(EV_ERR);
    place = 1'b1;
    tick();
    place = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (chk_req) cnt++;
      else if (cnt > 0) break;
    end
    tick();
    chk("timeout_req_cycles", 32'(cnt), 32'd16);
    chk("timeout_req_low", 32'(chk_req), 32'd0);
    chk("timeout_still_hold", 32'(sel_valid), 32'd1);
    read_sq(6, 0, 5'b00101);
    read_sq(5, 0, 5'b00000);

    // HOLD behaviours: place on held, reselect, select empty, place on own, deselect.
    step(1, 1, 1);
    evq.push_back(EV_ERR);
    press_place();
    chk("place_held_hold", 32'(sel_valid), 32'd1);
    step(0, 1, 1);
    press_sel();
    chk("reselect_sq", 32'({sel_row, sel_col}), 32'({3'd6, 3'd1}));
    step(1, 0, 1);
    evq.push_back(EV_ERR);
    press_sel();
    chk("sel_empty_hold", 32'(sel_valid), 32'd1);
    step(1, 1, 2);
    evq.push_back(EV_ERR);
    press_place();
    chk("place_own_hold", 32'(sel_valid), 32'd1);
    step(1, 0, 1);
    press_sel();
    chk("deselect", 32'(sel_valid), 32'd0);

    // Select and place together in IDLE: only place acts.
    evq.push_back(EV_ERR);
    select = 1'b1;
    place = 1'b1;
    tick();
    select = 1'b0;
    place = 1'b0;
    tick(); tick();
    chk("simul_place_only", 32'(sel_valid), 32'd0);

    tick(); tick();
    chk("events_drained", 32'(evq.size()), 32'd0);
    chk("reads_drained", 32'(rdq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
